// File: rtl/fir_pkg.sv
// fir_pkg
// Shared definitions for the time-multiplexed FIR engine.
// Contents:
//   DEF_DATA_W / DEF_TAPS / DEF_ACC_W  default widths and tap count
//   state_t                            sequencer states IDLE, MAC, TAIL
//   FRAC_BITS / ROUND_CONST            Q1.15 scaling and round-half-up constant
//   SAT_MAX / SAT_MIN                  output clamp limits for 16-bit PCM
package fir_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_TAPS   = 16;
  localparam int DEF_ACC_W  = 40;

  localparam int FRAC_BITS   = 15;
  localparam int ROUND_CONST = 1 << (FRAC_BITS - 1);

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    TAIL = 2'd2
  } state_t;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if
// Groups the sample stream, coefficient ROM port and output stream of the
// FIR engine. The slave modport is the engine; the master modport is whatever
// feeds samples, serves the coefficient ROM and consumes filtered samples.
// Signals:
//   in_valid/in_data/in_ready  input sample handshake
//   coef_addr/coef_data        coefficient ROM (data one cycle after address)
//   clear                      synchronous history flush / abort
//   out_valid/out_data         filtered sample, one-cycle valid pulse
//   busy                       engine is working on a sample
interface fir_mac_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 16
);

  localparam int ADDR_W = $clog2(TAPS);

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [DATA_W-1:0] coef_data;
  logic                     clear;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     busy;

  modport master (
    output in_valid, in_data, coef_data, clear,
    input  in_ready, coef_addr, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, coef_data, clear,
    output in_ready, coef_addr, out_valid, out_data, busy
  );

endinterface

// File: rtl/fir_mac.sv
// fir_mac
// Registered signed multiply-accumulate shared by all taps.
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   i_hist_q          signed history sample for the current product
//   i_coef_data       signed Q1.15 coefficient for the current product
//   i_clr             zero the accumulator (wins over i_en)
//   i_en              add the current product into the accumulator
//   o_acc_next        accumulator plus the current product, before the edge
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] i_hist_q,
  input  logic signed [DATA_W-1:0] i_coef_data,
  input  logic                     i_clr,
  input  logic                     i_en,
  output logic signed [ACC_W-1:0]  o_acc_next
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prodExt;
  logic signed [ACC_W-1:0]    r_acc;

  // Full-precision product, sign-extended so accumulation never wraps
  assign w_prod     = i_hist_q * i_coef_data;
  assign w_prodExt  = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign o_acc_next = r_acc + w_prodExt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_acc_next;
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Time-multiplexed FIR: each accepted sample goes into a circular history,
// then one shared MAC walks all taps against an external coefficient ROM and
// a rounded, saturated output sample is produced.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   bus (slave)    sample in, coefficient ROM, sample out, clear, busy
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic          clk,
  input  logic          reset_n,
  fir_mac_sequencer_if.slave bus
);

  localparam int PTR_W = $clog2(TAPS);
  localparam logic [PTR_W-1:0] LAST_TAP = PTR_W'(TAPS - 1);

  state_t                   r_state;
  state_t                   w_stateNext;
  logic [PTR_W-1:0]         r_wrPtr;
  logic [PTR_W-1:0]         r_tap;
  logic signed [DATA_W-1:0] r_hist [TAPS];
  logic signed [DATA_W-1:0] r_histQ;
  logic                     r_rdyEn;
  logic                     r_outValid;
  logic signed [DATA_W-1:0] r_outData;

  logic                     w_ready;
  logic                     w_accept;
  logic                     w_macEn;
  logic                     w_macClr;
  logic [PTR_W-1:0]         w_coefAddr;
  logic [PTR_W-1:0]         w_rdIdx;
  logic [PTR_W-1:0]         w_wrPtrInc;
  logic signed [ACC_W-1:0]  w_accNext;
  logic signed [ACC_W-1:0]  w_rounded;
  logic signed [DATA_W-1:0] w_sat;

  fir_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_hist_q    (r_histQ),
    .i_coef_data (bus.coef_data),
    .i_clr       (w_macClr),
    .i_en        (w_macEn),
    .o_acc_next  (w_accNext)
  );

  // r_rdyEn keeps in_ready low until the first edge after reset release
  assign w_ready  = (r_state == IDLE) && r_rdyEn && !bus.clear;
  assign w_accept = w_ready && bus.in_valid;

  // Read index (wr_ptr - tap) mod TAPS; adding TAPS keeps it correct for
  // tap counts that are not a power of two
  always_comb begin
    if (r_wrPtr >= r_tap) begin
      w_rdIdx = r_wrPtr - r_tap;
    end else begin
      w_rdIdx = PTR_W'(TAPS) + r_wrPtr - r_tap;
    end
    w_wrPtrInc = (r_wrPtr == LAST_TAP) ? '0 : r_wrPtr + 1'b1;
  end

  // Round half up, arithmetic shift back to Q1.15, then clamp to 16-bit PCM
  assign w_rounded = (w_accNext + ACC_W'(ROUND_CONST)) >>> FRAC_BITS;

  always_comb begin
    if (w_rounded > ACC_W'(SAT_MAX)) begin
      w_sat = DATA_W'(SAT_MAX);
    end else if (w_rounded < ACC_W'(SAT_MIN)) begin
      w_sat = DATA_W'(SAT_MIN);
    end else begin
      w_sat = w_rounded[DATA_W-1:0];
    end
  end

  // Next state and MAC control; the product of tap k is only available one
  // cycle later (registered ROM and hist_q), so tap 0 accumulates nothing
  always_comb begin
    w_stateNext = r_state;
    w_macEn     = 1'b0;
    w_macClr    = bus.clear;
    w_coefAddr  = '0;
    unique case (r_state)
      IDLE: begin
        w_macClr = 1'b1;
        if (w_accept) w_stateNext = MAC;
      end
      MAC: begin
        w_coefAddr = r_tap;
        w_macEn    = (r_tap != '0);
        if (r_tap == LAST_TAP) w_stateNext = TAIL;
      end
      TAIL: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
    if (bus.clear) w_stateNext = IDLE;
  end

  // State, history, pointers and output registers; clear wipes history and
  // suppresses the output update of an in-flight sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wrPtr    <= '0;
      r_tap      <= '0;
      r_histQ    <= '0;
      r_rdyEn    <= 1'b0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      for (int i = 0; i < TAPS; i++) r_hist[i] <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_rdyEn    <= 1'b1;
      r_outValid <= 1'b0;
      if (bus.clear) begin
        r_wrPtr <= '0;
        r_tap   <= '0;
        for (int i = 0; i < TAPS; i++) r_hist[i] <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_hist[r_wrPtr] <= bus.in_data;
              r_tap           <= '0;
            end
          end
          MAC: begin
            r_histQ <= r_hist[w_rdIdx];
            if (r_tap != LAST_TAP) r_tap <= r_tap + 1'b1;
          end
          TAIL: begin
            r_outValid <= 1'b1;
            r_outData  <= w_sat;
            r_wrPtr    <= w_wrPtrInc;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.coef_addr = w_coefAddr;
  assign bus.out_valid = r_outValid;
  assign bus.out_data  = r_outData;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer
// Directed bench for fir_mac_sequencer. Stimulus pushes hand-computed
// expected outputs into a queue; a monitor pops and compares on out_valid.
module tb_fir_mac_sequencer;

  localparam int DW  = 16;
  localparam int NT  = 16;
  localparam int LAT = NT + 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fir_mac_sequencer_if #(.DATA_W(DW), .TAPS(NT)) bus_if ();

  fir_mac_sequencer #(
    .DATA_W (DW),
    .TAPS   (NT),
    .ACC_W  (40)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Coefficient ROM with one cycle of read latency
  logic signed [DW-1:0] rom [NT];
  always @(posedge clk) bus_if.coef_data <= rom[bus_if.coef_addr];

  int expQ[$];
  int numVec = 0;
  int numErr = 0;
  int monExp;

  task automatic checkOutput(input string name, input int actual, input int expected);
    numVec++;
    if (actual != expected) begin
      numErr++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus_if.out_valid) begin
      if (expQ.size() == 0) begin
        numVec++;
        numErr++;
        $display("[TB] FAIL unexpected_out got=%0d expected=no output", int'(bus_if.out_data));
      end else begin
        monExp = expQ.pop_front();
        checkOutput("out_data", int'(bus_if.out_data), monExp);
      end
    end
  end

  task automatic waitReady();
    int n = 0;
    while (!bus_if.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.in_ready) checkOutput("accept_timeout", int'(bus_if.in_ready), 1);
  endtask

  task automatic applyStimulus(input int sample, input bit pushExp, input int expVal);
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = DW'(sample);
    waitReady();
    if (pushExp) expQ.push_back(expVal);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic drainOutputs();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_queue_empty", expQ.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Clear with a competing in_valid: the sample must not be accepted
  task automatic clearHistory();
    @(negedge clk);
    bus_if.clear    = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = DW'(12345);
    #1;
    checkOutput("in_ready_during_clear", int'(bus_if.in_ready), 0);
    @(negedge clk);
    bus_if.clear    = 1'b0;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic setRom(input int val, input int idx);
    for (int i = 0; i < NT; i++) rom[i] = (idx < 0 || idx == i) ? DW'(val) : '0;
  endtask

  task automatic runImpulse(input bit doClear);
    setRom(16'h4000, -1);
    if (doClear) clearHistory();
    applyStimulus(1000, 1'b1, 500);
    for (int i = 1; i < 20; i++) applyStimulus(0, 1'b1, (i < NT) ? 500 : 0);
    drainOutputs();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired, simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busyBad;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;
    bus_if.clear    = 1'b0;
    setRom(16'h4000, -1);

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", int'(bus_if.out_valid), 0);
    checkOutput("reset_out_data", int'(bus_if.out_data), 0);
    checkOutput("reset_busy", int'(bus_if.busy), 0);
    checkOutput("reset_coef_addr", int'(bus_if.coef_addr), 0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_after_reset", int'(bus_if.in_ready), 1);

    $display("[TB] impulse");
    runImpulse(1'b1);

    $display("[TB] delay tap / wrap");
    setRom(16'h4000, 3);
    clearHistory();
    for (int n = 0; n < 40; n++) applyStimulus(2 * (n + 1), 1'b1, (n < 3) ? 0 : n - 2);
    drainOutputs();

    $display("[TB] handshake / latency");
    setRom(16'h4000, -1);
    clearHistory();
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = DW'(2);
    waitReady();
    for (int k = 1; k <= 4; k++) begin
      checkOutput("held_accept_ready", int'(bus_if.in_ready), 1);
      expQ.push_back(k);
      busyBad = 0;
      for (int c = 1; c < LAT; c++) begin
        @(negedge clk);
        if (!bus_if.busy || bus_if.in_ready || bus_if.out_valid) busyBad++;
      end
      @(negedge clk);
      checkOutput("busy_window_bad_cycles", busyBad, 0);
      checkOutput("latency_out_valid", int'(bus_if.out_valid), 1);
    end
    bus_if.in_valid = 1'b0;
    drainOutputs();

    $display("[TB] saturation");
    setRom(16'h7FFF, -1);
    clearHistory();
    applyStimulus(32767, 1'b1, 32766);
    applyStimulus(32767, 1'b1, 32767);
    applyStimulus(32767, 1'b1, 32767);
    drainOutputs();
    clearHistory();
    applyStimulus(-32768, 1'b1, -32767);
    applyStimulus(-32768, 1'b1, -32768);
    applyStimulus(-32768, 1'b1, -32768);
    drainOutputs();

    $display("[TB] clear mid-MAC");
    setRom(16'h4000, -1);
    clearHistory();
    for (int j = 0; j < NT; j++) applyStimulus(1000, 1'b1, (j + 1) * 500);
    drainOutputs();
    applyStimulus(1000, 1'b0, 0);
    repeat (5) @(negedge clk);
    bus_if.clear = 1'b1;
    @(negedge clk);
    bus_if.clear = 1'b0;
    #1;
    checkOutput("in_ready_after_abort", int'(bus_if.in_ready), 1);
    checkOutput("busy_after_abort", int'(bus_if.busy), 0);
    repeat (LAT + 4) @(negedge clk);
    applyStimulus(1000, 1'b1, 500);
    drainOutputs();

    $display("[TB] async reset mid-MAC");
    applyStimulus(1000, 1'b0, 0);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", int'(bus_if.out_valid), 0);
    checkOutput("async_reset_out_data", int'(bus_if.out_data), 0);
    checkOutput("async_reset_busy", int'(bus_if.busy), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_after_release", int'(bus_if.in_ready), 1);
    runImpulse(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", numVec, numErr);
    $finish;
  end

endmodule
